// File: rtl/mips_bus_pkg.sv
// Shared types for the two-master MIPS bus arbiter.
// Arbiter states, master indices and grant encodings.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    function automatic logic [1:0] grant_of(arb_state_t s);
        case (s)
            GRANT0:  return GNT_M0;
            GRANT1:  return GNT_M1;
            default: return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts consecutive stalled cycles of the granted transfer.
// expired is high once the count has reached TIMEOUT_CYCLES-1.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    assign expired = (count == LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the
// fetch (m0) and data (m1) masters, with a stall timeout.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    input  logic        m0_read,
    input  logic        m0_write,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    input  logic        m1_read,
    input  logic        m1_write,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic [31:0] s_address,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    output logic        s_read,
    output logic        s_write,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    output logic [1:0]  grant,
    output logic        bus_error
);

    arb_state_t state, next_state;
    logic       last_grant;
    logic       req0, req1, req_sel;
    logic       stall, done, timeout, expired;
    logic       cnt_clear;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_comb begin
        req_sel = 1'b0;
        if (state == GRANT0) req_sel = req0;
        if (state == GRANT1) req_sel = req1;
    end

    assign stall   = req_sel & s_waitrequest;
    assign done    = req_sel & ~s_waitrequest;
    assign timeout = stall & expired;
    assign grant   = grant_of(state);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    next_state = (last_grant == M1) ? GRANT0 : GRANT1;
                else if (req0)
                    next_state = GRANT0;
                else if (req1)
                    next_state = GRANT1;
            end
            GRANT0: begin
                if (!req0 || timeout)
                    next_state = IDLE;
                else if (done)
                    next_state = req1 ? GRANT1 : IDLE;
            end
            GRANT1: begin
                if (!req1 || timeout)
                    next_state = IDLE;
                else if (done)
                    next_state = req0 ? GRANT0 : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Write wins when a master raises read and write together.
    always_comb begin
        s_address      = '0;
        s_writedata    = '0;
        s_byteenable   = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        m0_waitrequest = req0;
        m1_waitrequest = req1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        unique case (1'b1)
            (state == GRANT0): begin
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                s_write        = m0_write;
                s_read         = m0_read & ~m0_write;
                m0_waitrequest = s_waitrequest & ~timeout;
                m0_readdata    = timeout ? '0 : s_readdata;
            end
            (state == GRANT1): begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_write        = m1_write;
                s_read         = m1_read & ~m1_write;
                m1_waitrequest = s_waitrequest & ~timeout;
                m1_readdata    = timeout ? '0 : s_readdata;
            end
            default: ;
        endcase
    end

    assign cnt_clear = (state == IDLE) | done | (next_state != state);

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .enable (stall),
        .clear  (cnt_clear),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= M1;
            bus_error  <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == GRANT0) last_grant <= M0;
            if (next_state == GRANT1) last_grant <= M1;
            if (timeout) bus_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Table-driven bench for mips_bus_arbiter (TIMEOUT_CYCLES=8).
// Per-cycle vectors go through an expected-value queue.
module tb_mips_bus_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] Z = 32'h0;
    localparam logic [3:0] B0 = 4'h0;
    localparam logic [3:0] BF = 4'hF;

    typedef struct packed {
        logic        r0, w0;
        logic [31:0] a0, wd0;
        logic [3:0]  be0;
        logic        r1, w1;
        logic [31:0] a1, wd1;
        logic [3:0]  be1;
        logic        sw;
        logic [31:0] srd;
    } in_t;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        sr, swr;
        logic [31:0] sa, swd;
        logic [3:0]  sbe;
        logic        wt0;
        logic [31:0] rd0;
        logic        wt1;
        logic [31:0] rd1;
        logic        err;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk, reset;
    logic [31:0] m0_address, m0_writedata, m0_readdata;
    logic [3:0]  m0_byteenable;
    logic        m0_read, m0_write, m0_waitrequest;
    logic [31:0] m1_address, m1_writedata, m1_readdata;
    logic [3:0]  m1_byteenable;
    logic        m1_read, m1_write, m1_waitrequest;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic [3:0]  s_byteenable;
    logic        s_read, s_write, s_waitrequest;
    logic [1:0]  grant;
    logic        bus_error;

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];
    out_t exp_q[$];

    mips_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_writedata(m0_writedata),
        .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_writedata(m1_writedata),
        .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_writedata(s_writedata),
        .s_byteenable(s_byteenable),
        .s_read(s_read), .s_write(s_write),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant), .bus_error(bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drv(input in_t i);
        m0_read = i.r0;  m0_write = i.w0;
        m0_address = i.a0; m0_writedata = i.wd0;
        m0_byteenable = i.be0;
        m1_read = i.r1;  m1_write = i.w1;
        m1_address = i.a1; m1_writedata = i.wd1;
        m1_byteenable = i.be1;
        s_waitrequest = i.sw; s_readdata = i.srd;
    endtask

    function automatic out_t sample();
        out_t g;
        g = '{grant, s_read, s_write, s_address, s_writedata,
              s_byteenable, m0_waitrequest, m0_readdata,
              m1_waitrequest, m1_readdata, bus_error};
        return g;
    endfunction

    task automatic check(input string nm,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        out_t g, e;
        @(negedge clk);
        drv(v.i);
        exp_q.push_back(v.o);
        #2;
        g = sample();
        e = exp_q.pop_front();
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL vec%0d: got %h expected %h", n, g, e);
        end
    endtask

    function automatic void add(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        vecs.push_back(v);
    endfunction

    initial begin
        in_t idle_in;
        idle_in = '0;
        reset = 1'b0;
        drv(idle_in);

        // tie after reset: m0 first, m1 follows with no bubble
        add('{H,L,32'h100,Z,BF, H,L,32'h200,Z,BF, H,Z},
            '{2'b00,L,L,Z,Z,B0, H,Z, H,Z, L});
        add('{H,L,32'h100,Z,BF, H,L,32'h200,Z,BF, L,32'hA0A0A0A0},
            '{2'b01,H,L,32'h100,Z,BF, L,32'hA0A0A0A0, H,Z, L});
        add('{L,L,Z,Z,B0, H,L,32'h200,Z,BF, L,32'hB1B1B1B1},
            '{2'b10,H,L,32'h200,Z,BF, L,Z, L,32'hB1B1B1B1, L});
        add(idle_in, '0);
        // m0 fetch with two wait cycles
        add('{H,L,32'hBFC00000,Z,BF, L,L,Z,Z,B0, H,Z},
            '{2'b00,L,L,Z,Z,B0, H,Z, L,Z, L});
        for (int k = 0; k < 2; k++)
            add('{H,L,32'hBFC00000,Z,BF, L,L,Z,Z,B0, H,Z},
                '{2'b01,H,L,32'hBFC00000,Z,BF, H,Z, L,Z, L});
        add('{H,L,32'hBFC00000,Z,BF, L,L,Z,Z,B0, L,32'h12345678},
            '{2'b01,H,L,32'hBFC00000,Z,BF, L,32'h12345678, L,Z, L});
        add(idle_in, '0);
        // m1 partial write
        add('{L,L,Z,Z,B0, L,H,32'h300,32'hDEADBEEF,4'h3, L,Z},
            '{2'b00,L,L,Z,Z,B0, L,Z, H,Z, L});
        add('{L,L,Z,Z,B0, L,H,32'h300,32'hDEADBEEF,4'h3, L,Z},
            '{2'b10,L,H,32'h300,32'hDEADBEEF,4'h3, L,Z, L,Z, L});
        add(idle_in, '0);
        // read+write together forwards write only
        add('{H,H,32'h400,32'h55,BF, L,L,Z,Z,B0, L,Z},
            '{2'b00,L,L,Z,Z,B0, H,Z, L,Z, L});
        add('{H,H,32'h400,32'h55,BF, L,L,Z,Z,B0, L,Z},
            '{2'b01,L,H,32'h400,32'h55,BF, L,Z, L,Z, L});
        add(idle_in, '0);
        // m1 drops its request mid-stall
        add('{L,L,Z,Z,B0, H,L,32'h500,Z,BF, H,Z},
            '{2'b00,L,L,Z,Z,B0, L,Z, H,Z, L});
        add('{L,L,Z,Z,B0, H,L,32'h500,Z,BF, H,Z},
            '{2'b10,H,L,32'h500,Z,BF, L,Z, H,Z, L});
        add(idle_in, '{2'b10,L,L,Z,Z,B0, L,Z, L,Z, L});
        add(idle_in, '0);
        // timeout after 8 stalled granted cycles
        add('{H,L,32'h600,Z,BF, L,L,Z,Z,B0, H,32'hFFFFFFFF},
            '{2'b00,L,L,Z,Z,B0, H,Z, L,Z, L});
        for (int k = 0; k < 7; k++)
            add('{H,L,32'h600,Z,BF, L,L,Z,Z,B0, H,32'hFFFFFFFF},
                '{2'b01,H,L,32'h600,Z,BF, H,32'hFFFFFFFF, L,Z, L});
        add('{H,L,32'h600,Z,BF, L,L,Z,Z,B0, H,32'hFFFFFFFF},
            '{2'b01,H,L,32'h600,Z,BF, L,Z, L,Z, L});
        add(idle_in, '{2'b00,L,L,Z,Z,B0, L,Z, L,Z, H});
        add('{L,L,Z,Z,B0, H,L,32'h700,Z,BF, L,32'h77},
            '{2'b00,L,L,Z,Z,B0, L,Z, H,Z, H});
        add('{L,L,Z,Z,B0, H,L,32'h700,Z,BF, L,32'h77},
            '{2'b10,H,L,32'h700,Z,BF, L,Z, L,32'h77, H});
        add(idle_in, '{2'b00,L,L,Z,Z,B0, L,Z, L,Z, H});

        // reset state
        @(negedge clk);
        @(negedge clk);
        #2;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_srw", 32'({s_read, s_write}), 32'h0);
        check("rst_err", 32'(bus_error), 32'h0);
        reset = 1'b1;

        foreach (vecs[n]) run_vec(n, vecs[n]);

        // asynchronous reset during GRANT1
        @(negedge clk);
        drv('{L,L,Z,Z,B0, H,L,32'h800,Z,BF, H,Z});
        @(negedge clk);
        #2;
        check("g1_grant", 32'(grant), 32'h2);
        check("g1_sread", 32'(s_read), 32'h1);
        #1 reset = 1'b0;
        #1;
        check("arst_grant", 32'(grant), 32'h0);
        check("arst_srw", 32'({s_read, s_write}), 32'h0);
        check("arst_err", 32'(bus_error), 32'h0);
        check("arst_m1wait", 32'(m1_waitrequest), 32'h1);
        @(negedge clk);
        drv('{H,L,32'h900,Z,BF, H,L,32'h800,Z,BF, H,Z});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        drv('{H,L,32'h900,Z,BF, H,L,32'h800,Z,BF, L,32'h99});
        #2;
        check("post_grant", 32'(grant), 32'h1);
        check("post_saddr", s_address, 32'h900);
        check("post_m0rd", m0_readdata, 32'h99);
        check("post_m1wait", 32'(m1_waitrequest), 32'h1);
        @(negedge clk);
        drv('{L,L,Z,Z,B0, H,L,32'h800,Z,BF, L,32'h88});
        #2;
        check("post_grant1", 32'(grant), 32'h2);
        check("post_m1rd", m1_readdata, 32'h88);
        @(negedge clk);
        drv(idle_in);
        @(negedge clk);
        #2;
        check("end_grant", 32'(grant), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning maximum consecutive stalled cycles allowed per granted transfer.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports m0_address/m0_writedata  input  32 each, m0_byteenable  input  4, m0_read/m0_write  input  1 each: the instruction-fetch master request.
REQ-005 SHALL have ports m0_waitrequest  output  1, m0_readdata  output  32: the fetch master response.
REQ-006 SHALL have ports m1_address/m1_writedata  input  32, m1_byteenable  input  4, m1_read/m1_write  input  1: the data master request.
REQ-007 SHALL have ports m1_waitrequest  output  1, m1_readdata  output  32: the data master response.
REQ-008 SHALL have ports s_address/s_writedata  output  32, s_byteenable  output  4, s_read/s_write  output  1: the shared memory bus.
REQ-009 SHALL have ports s_waitrequest  input  1, s_readdata  input  32: the memory response.
REQ-010 SHALL have ports grant  output  2 (one-hot, bit0=m0, bit1=m1) and bus_error  output  1 (sticky timeout flag).

Function
REQ-011 SHALL implement states IDLE, GRANT0 and GRANT1; a master requests when its read or write input is high.
REQ-012 In IDLE, SHALL register a grant on the next edge to a requesting master; grant takes effect one cycle after the request is first seen.
REQ-013 On simultaneous requests, SHALL grant the master not granted last (round-robin); last_grant SHALL be m1 after reset, so m0 wins the first tie.
REQ-014 In GRANTx, SHALL drive s_* combinationally from master x and pass s_waitrequest and s_readdata to master x.
REQ-015 A non-granted master SHALL see waitrequest=1 while it requests, waitrequest=0 while idle, and readdata=0 at all times.
REQ-016 In IDLE, s_read and s_write SHALL be 0; s_address, s_writedata and s_byteenable SHALL be 0.
REQ-017 A transfer SHALL complete in the cycle where the master is granted, it requests, and s_waitrequest=0.
REQ-018 On completion, SHALL go to GRANT of the other master if that master is requesting, otherwise to IDLE, with no bubble cycle.
REQ-019 If the granted master drops both read and write before completion, SHALL go to IDLE on the next edge without completing.
REQ-020 SHALL count consecutive granted cycles with s_waitrequest=1; the counter SHALL clear on completion or grant change.
REQ-021 When the count reaches TIMEOUT_CYCLES-1 and s_waitrequest is still 1, SHALL force master waitrequest=0 with readdata=0, set bus_error, and go to IDLE.
REQ-022 bus_error SHALL stay set until reset; arbitration SHALL continue normally after a timeout.
REQ-023 s_read and s_write SHALL never both be 1; if a master asserts both, SHALL forward write only.

Reset
REQ-024 While reset=0, SHALL immediately force state IDLE, grant=0, s_read=0, s_write=0, bus_error=0, timeout counter 0, last_grant=m1.
REQ-025 A reset asserted mid-transfer SHALL abandon the transfer with no completion signalled to either master.

Structure
REQ-026 State enum, master index constants and the grant encoding SHALL live in shared package mips_bus_pkg.
REQ-027 The timeout counter SHALL be sub-module bus_timeout_counter (inputs: enable, clear; output: expired); everything else SHALL be in one module.

Verification
REQ-028 m0 reads 0xBFC00000 alone, memory has 2 wait cycles -> grant=01 one cycle later; m0 gets readdata=memory word on the third granted cycle; return to IDLE.
REQ-029 m0 and m1 request on the same edge after reset -> m0 granted first; m1 granted in the cycle after m0 completes, with no IDLE cycle.
REQ-030 m1 writes 0xDEADBEEF with byteenable=0011 while m0 is idle -> s_write=1, s_writedata=0xDEADBEEF, s_byteenable=0011; m0_waitrequest=0.
REQ-031 With TIMEOUT_CYCLES=8, s_waitrequest held 1 -> after 8 granted cycles, m0_waitrequest=0, m0_readdata=0, bus_error=1 and stays set.
REQ-032 Reset pulled low during GRANT1 -> s_read, s_write and grant go to 0 without a clock edge; after release, next request arbitrates with m0 priority.
